// File: rtl/wb_sram_responder.sv
// -----------------------------------------------------------------------------
// wb_sram_responder
//
// Wishbone classic responder that bridges the Caravel management bus onto
// port 0 (1rw) of a sky130_sram_2kbyte_1rw1r_32x512_8 macro. The management
// core uses it to preload IRAM/DRAM while the rvj1 core is held in reset.
//
// Accesses that fall outside the byte window [BASE_ADDR, BASE_ADDR + 2^(AW+2))
// are terminated with err and never touch the SRAM.
//
// Ports
//   clk_i        clock, also forwarded to the SRAM as sram_clk0
//   rstn_i       synchronous active-low reset
//   wbs_cyc_i    bus cycle valid
//   wbs_stb_i    strobe
//   wbs_we_i     1 = write, 0 = read
//   wbs_sel_i    byte lanes for writes (ignored on reads)
//   wbs_adr_i    byte address
//   wbs_dat_i    write data
//   wbs_ack_o    normal termination, one cycle
//   wbs_err_o    error termination (out of window), one cycle
//   wbs_dat_o    registered read data, held between reads
//   sram_clk0    SRAM port-0 clock
//   sram_csb0    SRAM chip select, active low
//   sram_web0    SRAM write enable, active low
//   sram_wmask0  SRAM byte write mask
//   sram_addr0   SRAM word address
//   sram_din0    SRAM write data
//   sram_dout0   SRAM read data, valid the cycle after the read edge
//
// Timing (from the first IDLE cycle the request is presented):
//   write ack at +1, read ack at +2, err at +1.
// -----------------------------------------------------------------------------
module wb_sram_responder #(
  parameter logic [31:0] BASE_ADDR        = 32'h3000_0000,
  parameter int          ADDR_WIDTH_WORDS = 9
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        wbs_cyc_i,
  input  logic                        wbs_stb_i,
  input  logic                        wbs_we_i,
  input  logic [3:0]                  wbs_sel_i,
  input  logic [31:0]                 wbs_adr_i,
  input  logic [31:0]                 wbs_dat_i,
  output logic                        wbs_ack_o,
  output logic                        wbs_err_o,
  output logic [31:0]                 wbs_dat_o,
  output logic                        sram_clk0,
  output logic                        sram_csb0,
  output logic                        sram_web0,
  output logic [3:0]                  sram_wmask0,
  output logic [ADDR_WIDTH_WORDS-1:0] sram_addr0,
  output logic [31:0]                 sram_din0,
  input  logic [31:0]                 sram_dout0
);

  localparam logic [31:0] WIN_BYTES = 32'd1 << (ADDR_WIDTH_WORDS + 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t      state_q;
  logic        ack_q;
  logic        err_q;
  logic [31:0] dat_q;

  logic        req;
  logic        hit;
  logic [31:0] offset;
  logic        access;

  assign req    = wbs_cyc_i & wbs_stb_i;
  // Unsigned wrap-around makes addresses below BASE_ADDR huge, so one compare
  // covers both ends of the window.
  assign offset = wbs_adr_i - BASE_ADDR;
  assign hit    = (offset < WIN_BYTES);

  // The SRAM is only strobed in the acceptance cycle; RD_WAIT/RESP never
  // start a second access even if the master keeps stb high.
  assign access = (state_q == IDLE) & req & hit;

  // SRAM port 0 is driven combinationally so the access happens on the same
  // edge that accepts the request. Write strobes are forced inactive while
  // reset is asserted so nothing can be committed during reset.
  assign sram_clk0   = clk_i;
  assign sram_csb0   = ~(rstn_i & access);
  assign sram_web0   = ~(rstn_i & wbs_we_i);
  assign sram_wmask0 = (rstn_i & wbs_we_i) ? wbs_sel_i : 4'h0;
  assign sram_addr0  = offset[ADDR_WIDTH_WORDS+1:2];
  assign sram_din0   = wbs_dat_i;

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = dat_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'h0;
    end else begin
      // ack/err are single-cycle pulses: default low, raised only on entry
      // to RESP.
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (!hit) begin
              err_q   <= 1'b1;
              dat_q   <= 32'h0;
              state_q <= RESP;
            end else if (wbs_we_i) begin
              // Write was committed by the SRAM on this same edge.
              ack_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (!wbs_cyc_i) begin
            // Master abandoned the cycle: drop the read silently.
            state_q <= IDLE;
          end else begin
            dat_q   <= sram_dout0;
            ack_q   <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_sram_responder.md
Name: wb_sram_responder

Overview:
- Wishbone classic slave (responder) that serves word reads and byte-masked writes from the Caravel management bus into one sky130_sram_2kbyte_1rw1r_32x512_8 port 0.
- Lets the management core preload IRAM/DRAM while the rvj1 core is held in reset.
- Sits between the wbs_* bus and the SRAM port-0 pins (clk0/csb0/web0/wmask0/addr0/din0/dout0).
- Returns err instead of ack for addresses outside its window.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte base address of the window.
- ADDR_WIDTH_WORDS, 9, SRAM word-address width. Window size = 2^(ADDR_WIDTH_WORDS+2) bytes.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe.
- wbs_we_i  in  1  1=write.
- wbs_sel_i  in  4  byte lanes.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  normal termination.
- wbs_err_o  out  1  error termination (out of window).
- wbs_dat_o  out  32  read data (registered).
- sram_clk0  out  1  = clk_i.
- sram_csb0  out  1  chip select, active low.
- sram_web0  out  1  write enable, active low.
- sram_wmask0  out  4  byte write mask.
- sram_addr0  out  ADDR_WIDTH_WORDS  word address.
- sram_din0  out  32  write data.
- sram_dout0  in  32  read data, valid the cycle after the read edge.

Behaviour:
- One clock (clk_i). Reset rstn_i is synchronous, active-low.
- Reset values: state=IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_dat_o=0. While rstn_i=0: sram_csb0=1, sram_web0=1, sram_wmask0=0.
- req = wbs_cyc_i & wbs_stb_i.
- hit = (wbs_adr_i - BASE_ADDR) < 2^(ADDR_WIDTH_WORDS+2), computed unsigned in 32 bits.
- sram_addr0 = (wbs_adr_i - BASE_ADDR)[ADDR_WIDTH_WORDS+1:2]. wbs_adr_i[1:0] is ignored.
- SRAM port outputs are combinational:
  - sram_csb0 = ~(state==IDLE & req & hit)
  - sram_web0 = ~wbs_we_i
  - sram_wmask0 = wbs_we_i ? wbs_sel_i : 0
  - sram_din0 = wbs_dat_i
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE:
  - req & hit & we: write commits at the edge; go to RESP with ack.
  - req & hit & ~we: go to RD_WAIT.
  - req & ~hit: go to RESP with err, wbs_dat_o=0, no SRAM access.
  - no req: stay in IDLE.
- RD_WAIT: if wbs_cyc_i=0 (abort), go to IDLE with no ack. Otherwise register sram_dout0 into wbs_dat_o and go to RESP with ack.
- RESP: wbs_ack_o or wbs_err_o is high for exactly this one cycle; go to IDLE unconditionally.
- Latency, counted from the first cycle req is presented in IDLE:
  - write ack: cycle +1
  - read ack: cycle +2
  - err: cycle +1
- ack and err are never both high. No new request is accepted in RD_WAIT or RESP.
- Back-to-back: a new request presented in the IDLE cycle after RESP is accepted in that cycle.
- wbs_sel_i=0 write: SRAM is selected with wmask0=0, memory is unchanged, ack is still returned.
- Reads ignore wbs_sel_i and always return the full word.
- wbs_dat_o holds its last value between reads. An err transaction sets it to 0.
- Reset mid-operation: the next edge forces IDLE and clears ack/err. A write already committed stays in memory. A pending read is dropped.
- Abort by cyc drop: a write is already committed. A read is dropped, no ack is issued, and SRAM contents are unchanged.

Test Plan:
- Write adr=0x3000_0010, dat=0xDEAD_BEEF, sel=4'hF -> csb0=0, web0=0, addr0=4, wmask0=F in the issue cycle; ack one cycle later. A read of the same address then returns 0xDEAD_BEEF with ack 2 cycles after issue.
- Byte write sel=4'b0010, dat=0x0000_AB00 to a word holding 0x1122_3344 -> readback 0x1122_AB44.
- Out-of-window accesses: read at 0x3000_0800 with defaults gives err one cycle later, ack=0, dat_o=0, csb0 stays 1. Same for 0x2FFF_FFFC.
- Window edge: address 0x3000_07FC -> addr0=511, ack. Back-to-back reads of 0x3000_0000 and 0x3000_0004 with stb held high -> two acks spaced 3 cycles apart, correct data each.
- Read issued, then cyc dropped during RD_WAIT -> no ack; FSM back in IDLE; the next read completes normally.
- rstn_i=0 asserted during RD_WAIT -> ack=0, err=0, dat_o=0 after the edge. A write committed just before reset reads back intact.
